// File: rtl/port_shadow_commit_pkg.sv
// Shared RTC port map: channel/commit port ids, default decode mask and the
// commit sequencer state encoding.
package port_map_pkg;

   localparam int                    RTC_N_REGS      = 11;
   localparam int                    RTC_IDX_W       = 4;
   localparam logic [7:0]            RTC_BASE_ADDR   = 8'h03;
   localparam logic [7:0]            RTC_LAST_ADDR   = 8'h0D;
   localparam logic [7:0]            RTC_COMMIT_ADDR = 8'h0F;
   // Port 0x09 has no RTC register behind it, so bit 6 is left clear.
   localparam logic [RTC_N_REGS-1:0] RTC_VALID_MASK  = 11'h7BF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_REQ  = 2'd2,
      ST_DONE = 2'd3
   } commit_state_t;

endpackage

// File: rtl/port_shadow_commit_if.sv
// PicoBlaze write port plus RTC-driver handshake, bundled for port_shadow_commit.
interface port_shadow_commit_if #(
   parameter int N_REGS = 11,
   parameter int DATA_W = 8,
   parameter int IDX_W  = 4
);
   logic              write_strobe;
   logic [7:0]        port_id;
   logic [DATA_W-1:0] out_port;
   logic [N_REGS-1:0] hold_n;
   logic [N_REGS-1:0] dirty;
   logic              wr_req;
   logic [IDX_W-1:0]  wr_idx;
   logic [DATA_W-1:0] wr_data;
   logic              wr_ack;
   logic              busy;
   logic              commit_done;

   modport master (
      output write_strobe, port_id, out_port, wr_ack,
      input  hold_n, dirty, wr_req, wr_idx, wr_data, busy, commit_done
   );

   modport slave (
      input  write_strobe, port_id, out_port, wr_ack,
      output hold_n, dirty, wr_req, wr_idx, wr_data, busy, commit_done
   );
endinterface

// File: rtl/port_shadow_commit_hold_stretch.sv
// Per-channel hold stretcher: a hit pulls hold_n low for exactly HOLD_CYCLES
// cycles; a hit while already low reloads the count without releasing hold_n.
module hold_stretch #(
   parameter int HOLD_CYCLES = 4
)(
   input  logic clk,
   input  logic reset,
   input  logic hit,
   output logic hold_n
);
   localparam int               CNT_W    = $clog2(HOLD_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(HOLD_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [CNT_W-1:0] cnt_r;
   logic             hold_n_r;

   // hold_n is registered alongside the counter so it releases on the edge the count expires
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_r    <= '0;
         hold_n_r <= 1'b1;
      end else if (hit) begin
         cnt_r    <= CNT_LOAD;
         hold_n_r <= 1'b0;
      end else if (cnt_r > CNT_ONE) begin
         cnt_r    <= cnt_r - CNT_ONE;
         hold_n_r <= 1'b0;
      end else begin
         cnt_r    <= '0;
         hold_n_r <= 1'b1;
      end
   end

   assign hold_n = hold_n_r;

endmodule

// File: rtl/port_shadow_commit.sv
// Shadows PicoBlaze port writes for the RTC registers and, on a commit write,
// hands every dirty channel (lowest index first) to the RTC bus driver.
module port_shadow_commit
   import port_map_pkg::*;
#(
   parameter int                N_REGS      = RTC_N_REGS,
   parameter logic [7:0]        BASE_ADDR   = RTC_BASE_ADDR,
   parameter logic [N_REGS-1:0] VALID_MASK  = RTC_VALID_MASK,
   parameter logic [7:0]        COMMIT_ADDR = RTC_COMMIT_ADDR,
   parameter int                DATA_W      = 8,
   parameter int                HOLD_CYCLES = 4,
   parameter int                IDX_W       = RTC_IDX_W
)(
   input logic                 clk,
   input logic                 reset,
   port_shadow_commit_if.slave bus
);
   localparam int WIN_LO = int'(BASE_ADDR);
   localparam int WIN_HI = WIN_LO + N_REGS - 1;

   generate
      if ((int'(COMMIT_ADDR) >= WIN_LO) && (int'(COMMIT_ADDR) <= WIN_HI)) begin : g_bad_commit_addr
         $error("port_shadow_commit: COMMIT_ADDR falls inside the channel window");
      end
   endgenerate

   commit_state_t     state_r;
   commit_state_t     state_nx;
   logic [N_REGS-1:0] hit_s;
   logic              commit_hit_s;
   logic [N_REGS-1:0] hold_n_s;
   logic [N_REGS-1:0] dirty_r;
   logic [N_REGS-1:0] dirty_nx;
   logic [DATA_W-1:0] shadow_r [N_REGS];
   logic [IDX_W-1:0]  scan_idx_s;
   logic              any_dirty_s;
   logic              ack_take_s;
   logic [IDX_W-1:0]  wr_idx_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              wr_req_r;
   logic              busy_r;
   logic              done_r;

   for (genvar i = 0; i < N_REGS; i++) begin : g_ch
      localparam logic [7:0] CH_ADDR = 8'(WIN_LO + i);

      assign hit_s[i] = bus.write_strobe & (bus.port_id == CH_ADDR) & VALID_MASK[i];

      hold_stretch #(.HOLD_CYCLES(HOLD_CYCLES)) u_hold (
         .clk    (clk),
         .reset  (reset),
         .hit    (hit_s[i]),
         .hold_n (hold_n_s[i])
      );
   end

   assign commit_hit_s = bus.write_strobe & (bus.port_id == COMMIT_ADDR);
   assign any_dirty_s  = |dirty_r;
   assign ack_take_s   = (state_r == ST_REQ) & bus.wr_ack;

   // Lowest set dirty bit: scan downwards so the smallest index is written last
   always_comb begin
      scan_idx_s = '0;
      for (int i = N_REGS - 1; i >= 0; i--) begin
         scan_idx_s = dirty_r[i] ? IDX_W'(i) : scan_idx_s;
      end
   end

   // Retire the acknowledged channel; a same-cycle rewrite keeps it dirty for a resend
   always_comb begin
      dirty_nx = dirty_r;
      for (int i = 0; i < N_REGS; i++) begin
         if (ack_take_s && (wr_idx_r == IDX_W'(i))) begin
            dirty_nx[i] = 1'b0;
         end else begin
            dirty_nx[i] = dirty_r[i];
         end
      end
      dirty_nx = dirty_nx | hit_s;
   end

   // Commit sequencer next-state
   always_comb begin
      state_nx = state_r;
      case (state_r)
         ST_IDLE: state_nx = commit_hit_s ? ST_SCAN : ST_IDLE;
         ST_SCAN: state_nx = any_dirty_s  ? ST_REQ  : ST_DONE;
         ST_REQ:  state_nx = bus.wr_ack   ? ST_SCAN : ST_REQ;
         ST_DONE: state_nx = ST_IDLE;
         default: state_nx = ST_IDLE;
      endcase
   end

   // Commit sequencer state register
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nx;
      end
   end

   // Shadows, dirty flags and the registered driver-side outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N_REGS; i++) begin
            shadow_r[i] <= '0;
         end
         dirty_r   <= '0;
         wr_idx_r  <= '0;
         wr_data_r <= '0;
         wr_req_r  <= 1'b0;
         busy_r    <= 1'b0;
         done_r    <= 1'b0;
      end else begin
         for (int i = 0; i < N_REGS; i++) begin
            if (hit_s[i]) begin
               shadow_r[i] <= bus.out_port;
            end
         end
         dirty_r <= dirty_nx;
         // Snapshot taken at the scan; later shadow writes do not disturb the transfer
         if ((state_r == ST_SCAN) && any_dirty_s) begin
            wr_idx_r  <= scan_idx_s;
            wr_data_r <= shadow_r[scan_idx_s];
         end
         wr_req_r <= (state_nx == ST_REQ);
         busy_r   <= (state_nx != ST_IDLE);
         done_r   <= (state_nx == ST_DONE);
      end
   end

   assign bus.hold_n      = hold_n_s;
   assign bus.dirty       = dirty_r;
   assign bus.wr_req      = wr_req_r;
   assign bus.wr_idx      = wr_idx_r;
   assign bus.wr_data     = wr_data_r;
   assign bus.busy        = busy_r;
   assign bus.commit_done = done_r;

endmodule

// File: tb/tb_port_shadow_commit.sv
// Self-checking bench: directed RTC scenarios then random traffic, all checked
// cycle by cycle against an event-level reference model.
module tb_port_shadow_commit;

   localparam int          N     = 11;
   localparam int          DW    = 8;
   localparam int          IW    = 4;
   localparam int          HOLD  = 4;
   localparam logic [7:0]  BASE  = 8'h03;
   localparam logic [7:0]  CADDR = 8'h0F;
   localparam logic [10:0] VMASK = 11'h7BF;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   port_shadow_commit_if #(.N_REGS(N), .DATA_W(DW), .IDX_W(IW)) pb ();

   port_shadow_commit #(
      .N_REGS(N), .BASE_ADDR(BASE), .VALID_MASK(VMASK), .COMMIT_ADDR(CADDR),
      .DATA_W(DW), .HOLD_CYCLES(HOLD), .IDX_W(IW)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (pb)
   );

   // Reference model: shadows, dirty set, last-hit timestamps, transfer engine flags
   logic [7:0]   m_shadow [N];
   logic [N-1:0] m_dirty;
   int           m_last_hit [N];
   int           edge_n;
   bit           m_scan_due;
   bit           m_req_open;
   bit           m_done;
   logic [IW-1:0] m_req_idx;
   logic [7:0]   m_req_data;

   int n_vec = 0;
   int n_bad = 0;
   int req_age = 0;
   int ack_delay = 3;
   bit prev_req = 1'b0;
   int done_cnt = 0;
   int xq_idx [$];
   int xq_data [$];

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < N; i++) begin
         m_shadow[i]   = 8'h00;
         m_last_hit[i] = -1000;
      end
      m_dirty    = '0;
      m_scan_due = 1'b0;
      m_req_open = 1'b0;
      m_done     = 1'b0;
      m_req_idx  = '0;
      m_req_data = 8'h00;
   endtask

   task automatic model_edge(input bit rst, input bit ws, input logic [7:0] pid,
                             input logic [7:0] dat, input bit ack);
      int hit;
      bit commit;
      logic [N-1:0] d;
      edge_n++;
      if (rst) begin
         model_reset();
         return;
      end
      hit = -1;
      for (int i = 0; i < N; i++) begin
         if (ws && (int'(pid) == int'(BASE) + i) && VMASK[i]) hit = i;
      end
      commit = ws && (pid == CADDR);
      d = m_dirty;
      if (m_done) begin
         m_done = 1'b0;
      end else if (m_req_open) begin
         if (ack) begin
            d[m_req_idx] = 1'b0;
            m_req_open   = 1'b0;
            m_scan_due   = 1'b1;
         end
      end else if (m_scan_due) begin
         m_scan_due = 1'b0;
         if (m_dirty != '0) begin
            bit found = 1'b0;
            for (int i = 0; i < N; i++) begin
               if (!found && m_dirty[i]) begin
                  found      = 1'b1;
                  m_req_idx  = IW'(i);
                  m_req_data = m_shadow[i];
               end
            end
            m_req_open = 1'b1;
         end else begin
            m_done = 1'b1;
         end
      end else if (commit) begin
         m_scan_due = 1'b1;
      end
      if (hit >= 0) begin
         m_shadow[hit]   = dat;
         d[hit]          = 1'b1;
         m_last_hit[hit] = edge_n;
      end
      m_dirty = d;
   endtask

   task automatic step(input bit rst, input bit ws, input logic [7:0] pid,
                       input logic [7:0] dat, input bit noise);
      bit ack;
      bit was_open;
      logic [N-1:0] eh;
      ack = m_req_open ? (req_age >= ack_delay) : noise;
      reset           = rst;
      pb.write_strobe = ws;
      pb.port_id      = pid;
      pb.out_port     = dat;
      pb.wr_ack       = ack;
      was_open        = m_req_open;
      @(posedge clk);
      model_edge(rst, ws, pid, dat, ack);
      if (m_req_open && !was_open) req_age = 0;
      else if (m_req_open)         req_age++;
      else                         req_age = 0;
      #1;
      for (int i = 0; i < N; i++) eh[i] = !((edge_n - m_last_hit[i]) < HOLD);
      chk("hold_n",      64'(pb.hold_n),      64'(eh));
      chk("dirty",       64'(pb.dirty),       64'(m_dirty));
      chk("wr_req",      64'(pb.wr_req),      64'(m_req_open));
      chk("wr_idx",      64'(pb.wr_idx),      64'(m_req_idx));
      chk("wr_data",     64'(pb.wr_data),     64'(m_req_data));
      chk("busy",        64'(pb.busy),        64'(m_scan_due | m_req_open | m_done));
      chk("commit_done", 64'(pb.commit_done), 64'(m_done));
      if (pb.wr_req && !prev_req) begin
         xq_idx.push_back(int'(pb.wr_idx));
         xq_data.push_back(int'(pb.wr_data));
      end
      prev_req = pb.wr_req;
      if (pb.commit_done) done_cnt++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic wr(input logic [7:0] pid, input logic [7:0] dat);
      step(1'b0, 1'b1, pid, dat, 1'b0);
   endtask

   task automatic drain(input int budget);
      int n = 0;
      while ((m_scan_due || m_req_open || m_done) && (n < budget)) begin
         idle(1);
         n++;
      end
      idle(1);
      chk("drain_idle", 64'(pb.busy), 64'd0);
   endtask

   task automatic clear_log();
      xq_idx.delete();
      xq_data.delete();
      done_cnt = 0;
   endtask

   initial begin
      reset = 1'b1;
      pb.write_strobe = 1'b0;
      pb.port_id = 8'h00;
      pb.out_port = 8'h00;
      pb.wr_ack = 1'b0;
      edge_n = 0;
      model_reset();

      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      chk("rst_hold_n", 64'(pb.hold_n), 64'h7FF);
      chk("rst_dirty",  64'(pb.dirty),  64'h000);
      idle(2);

      // single write to channel 1
      wr(8'h04, 8'h59);
      chk("w1_hold_lo", 64'(pb.hold_n[1]), 64'd0);
      chk("w1_dirty",   64'(pb.dirty),     64'h002);
      idle(3);
      chk("w1_hold_c4", 64'(pb.hold_n[1]), 64'd0);
      idle(1);
      chk("w1_hold_up", 64'(pb.hold_n[1]), 64'd1);
      // unmapped and out-of-window ids
      wr(8'h09, 8'hAA);
      wr(8'h20, 8'hBB);
      chk("unmap_dirty", 64'(pb.dirty),  64'h002);
      chk("unmap_hold",  64'(pb.hold_n), 64'h7FF);
      clear_log();
      wr(CADDR, 8'h00);
      drain(200);
      chk("w1_xfer_n",   64'(xq_idx.size()), 64'd1);
      if (xq_idx.size() > 0) begin
         chk("w1_xfer_idx",  64'(xq_idx[0]),  64'd1);
         chk("w1_xfer_data", 64'(xq_data[0]), 64'h59);
      end

      // three channels, ack 3 cycles after each request
      ack_delay = 3;
      wr(8'h05, 8'hA5);
      wr(8'h03, 8'h3C);
      wr(8'h0D, 8'hD7);
      clear_log();
      wr(CADDR, 8'h00);
      idle(1);
      chk("lat_req", 64'(pb.wr_req), 64'd1);
      drain(200);
      chk("c3_xfer_n", 64'(xq_idx.size()), 64'd3);
      if (xq_idx.size() == 3) begin
         chk("c3_idx0", 64'(xq_idx[0]), 64'd0);  chk("c3_dat0", 64'(xq_data[0]), 64'h3C);
         chk("c3_idx1", 64'(xq_idx[1]), 64'd2);  chk("c3_dat1", 64'(xq_data[1]), 64'hA5);
         chk("c3_idx2", 64'(xq_idx[2]), 64'd10); chk("c3_dat2", 64'(xq_data[2]), 64'hD7);
      end
      chk("c3_done_n", 64'(done_cnt), 64'd1);
      chk("c3_dirty",  64'(pb.dirty), 64'h000);

      // empty commit
      clear_log();
      wr(CADDR, 8'h00);
      chk("empty_done_c1", 64'(pb.commit_done), 64'd0);
      idle(1);
      chk("empty_done_c2", 64'(pb.commit_done), 64'd1);
      drain(20);
      chk("empty_no_req", 64'(xq_idx.size()), 64'd0);
      chk("empty_done_n", 64'(done_cnt), 64'd1);

      // rewrite of the channel in flight, in the ack cycle
      wr(8'h05, 8'h22);
      clear_log();
      wr(CADDR, 8'h00);
      for (int k = 0; k < 50 && !(m_req_open && m_req_idx == 4'd2 && req_age >= ack_delay); k++) idle(1);
      wr(8'h05, 8'h11);
      chk("race_dirty2", 64'(pb.dirty[2]), 64'd1);
      drain(200);
      chk("race_xfer_n", 64'(xq_idx.size()), 64'd2);
      if (xq_idx.size() == 2) begin
         chk("race_idx0", 64'(xq_idx[0]), 64'd2); chk("race_dat0", 64'(xq_data[0]), 64'h22);
         chk("race_idx1", 64'(xq_idx[1]), 64'd2); chk("race_dat1", 64'(xq_data[1]), 64'h11);
      end

      // second commit while busy
      wr(8'h03, 8'h44);
      clear_log();
      wr(CADDR, 8'h00);
      idle(2);
      wr(CADDR, 8'h00);
      drain(200);
      chk("busy_done_n", 64'(done_cnt), 64'd1);
      chk("busy_xfer_n", 64'(xq_idx.size()), 64'd1);

      // reset held two cycles in the middle of a request
      wr(8'h03, 8'h55);
      wr(CADDR, 8'h00);
      idle(2);
      chk("mid_req_on", 64'(pb.wr_req), 64'd1);
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0);
      idle(1);
      chk("mid_rst_req",   64'(pb.wr_req), 64'd0);
      chk("mid_rst_busy",  64'(pb.busy),   64'd0);
      chk("mid_rst_dirty", 64'(pb.dirty),  64'h000);
      chk("mid_rst_hold",  64'(pb.hold_n), 64'h7FF);

      // random traffic
      for (int k = 0; k < 1500; k++) begin
         int pick;
         logic [7:0] pid;
         if (k % 100 == 0) ack_delay = $urandom_range(0, 4);
         pick = $urandom_range(0, 15);
         if (pick < 11)       pid = 8'(int'(BASE) + pick);
         else if (pick == 11) pid = CADDR;
         else                 pid = 8'($urandom_range(0, 255));
         step($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, pid,
              8'($urandom_range(0, 255)), $urandom_range(0, 7) == 0);
      end
      drain(400);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
